// File: rtl/video_timing_gen_pkg.sv
// Shared raster timing constants for the video timing generator.
// Holds the VGA 640x480@60 and XGA 1024x768@60 timings, the position width and
// a helper that turns a "sync window active" decode into a pin level.
package video_timing_pkg;

    localparam int POS_W  = 11;
    localparam int FCNT_W = 10;

    // VGA 640x480@60 (25.175 MHz pixel clock)
    localparam int   VGA_H_ACTIVE  = 640;
    localparam int   VGA_H_FP      = 16;
    localparam int   VGA_H_SYNC    = 96;
    localparam int   VGA_H_BP      = 48;
    localparam int   VGA_V_ACTIVE  = 480;
    localparam int   VGA_V_FP      = 10;
    localparam int   VGA_V_SYNC    = 2;
    localparam int   VGA_V_BP      = 33;
    localparam logic VGA_HSYNC_POL = 1'b0;
    localparam logic VGA_VSYNC_POL = 1'b0;

    // XGA 1024x768@60 (65 MHz pixel clock)
    localparam int   XGA_H_ACTIVE  = 1024;
    localparam int   XGA_H_FP      = 24;
    localparam int   XGA_H_SYNC    = 136;
    localparam int   XGA_H_BP      = 160;
    localparam int   XGA_V_ACTIVE  = 768;
    localparam int   XGA_V_FP      = 3;
    localparam int   XGA_V_SYNC    = 6;
    localparam int   XGA_V_BP      = 29;
    localparam logic XGA_HSYNC_POL = 1'b0;
    localparam logic XGA_VSYNC_POL = 1'b0;

    // Drive the polarity level while inside the sync window, its inverse outside.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/video_timing_gen_axis_counter.sv
// One raster axis: wrapping position counter with active-region and
// sync-window decodes. The decodes describe the counter's current value,
// which is the position the top level will present on the next enabled edge.
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter int TOTAL      = 1344,
    parameter int ACTIVE     = 1024,
    parameter int SYNC_START = 1048,
    parameter int SYNC_END   = 1184
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [POS_W-1:0] cnt,
    output logic             wrap,
    output logic             active,
    output logic             sync_on
);

    localparam logic [POS_W-1:0] LAST_L  = POS_W'(TOTAL - 1);
    localparam logic [POS_W-1:0] ACT_L   = POS_W'(ACTIVE);
    localparam logic [POS_W-1:0] SSTA_L  = POS_W'(SYNC_START);
    localparam logic [POS_W-1:0] SEND_L  = POS_W'(SYNC_END);
    localparam logic [POS_W-1:0] ONE_L   = POS_W'(1);

    logic [POS_W-1:0] cnt_r;

    // Advance the position on each increment, wrapping after the last position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (inc) begin
            if (cnt_r == LAST_L) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + ONE_L;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Pure compare decodes of the current position; no arithmetic on the path.
    always_comb begin
        wrap    = (cnt_r == LAST_L);
        active  = (cnt_r < ACT_L);
        sync_on = (cnt_r >= SSTA_L) && (cnt_r < SEND_L);
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: registered hsync/vsync, video-active, pixel
// coordinates, line/frame start pulses and a free-running frame counter,
// all aligned to the same pixel and living entirely in the clk domain.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   DISPLAY_MODE = 1,
    parameter int   H_ACTIVE  = (DISPLAY_MODE == 1) ? XGA_H_ACTIVE : VGA_H_ACTIVE,
    parameter int   H_FP      = (DISPLAY_MODE == 1) ? XGA_H_FP     : VGA_H_FP,
    parameter int   H_SYNC    = (DISPLAY_MODE == 1) ? XGA_H_SYNC   : VGA_H_SYNC,
    parameter int   H_BP      = (DISPLAY_MODE == 1) ? XGA_H_BP     : VGA_H_BP,
    parameter int   V_ACTIVE  = (DISPLAY_MODE == 1) ? XGA_V_ACTIVE : VGA_V_ACTIVE,
    parameter int   V_FP      = (DISPLAY_MODE == 1) ? XGA_V_FP     : VGA_V_FP,
    parameter int   V_SYNC    = (DISPLAY_MODE == 1) ? XGA_V_SYNC   : VGA_V_SYNC,
    parameter int   V_BP      = (DISPLAY_MODE == 1) ? XGA_V_BP     : VGA_V_BP,
    parameter logic HSYNC_POL = (DISPLAY_MODE == 1) ? XGA_HSYNC_POL : VGA_HSYNC_POL,
    parameter logic VSYNC_POL = (DISPLAY_MODE == 1) ? XGA_VSYNC_POL : VGA_VSYNC_POL
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    output logic                hsync,
    output logic                vsync,
    output logic                video_active,
    output logic [POS_W-1:0]    pix_x,
    output logic [POS_W-1:0]    pix_y,
    output logic                line_start,
    output logic                frame_start,
    output logic [FCNT_W-1:0]   frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [POS_W-1:0]  h_cnt_s;
    logic [POS_W-1:0]  v_cnt_s;
    logic              h_wrap_s;
    logic              v_wrap_s;
    logic              h_act_s;
    logic              v_act_s;
    logic              h_sync_s;
    logic              v_sync_s;
    logic              v_inc_s;
    logic              h_first_s;
    logic              frame_first_s;
    logic              frame_wrap_s;

    logic              hsync_r;
    logic              vsync_r;
    logic              video_active_r;
    logic [POS_W-1:0]  pix_x_r;
    logic [POS_W-1:0]  pix_y_r;
    logic              line_start_r;
    logic              frame_start_r;
    logic [FCNT_W-1:0] frame_cnt_r;
    logic              wrap_pend_r;

    assign v_inc_s = en & h_wrap_s;

    timing_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
    ) u_h_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (en),
        .cnt     (h_cnt_s),
        .wrap    (h_wrap_s),
        .active  (h_act_s),
        .sync_on (h_sync_s)
    );

    timing_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
    ) u_v_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (v_inc_s),
        .cnt     (v_cnt_s),
        .wrap    (v_wrap_s),
        .active  (v_act_s),
        .sync_on (v_sync_s)
    );

    // Decodes of the position about to be presented.
    always_comb begin
        h_first_s     = (h_cnt_s == '0);
        frame_first_s = h_first_s && (v_cnt_s == '0);
        frame_wrap_s  = h_wrap_s && v_wrap_s;
    end

    // Output register stage: every output describes the same pixel; pulses drop while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_x_r        <= '0;
            pix_y_r        <= '0;
            video_active_r <= 1'b0;
            hsync_r        <= sync_level(1'b0, HSYNC_POL);
            vsync_r        <= sync_level(1'b0, VSYNC_POL);
            line_start_r   <= 1'b0;
            frame_start_r  <= 1'b0;
        end else if (en) begin
            pix_x_r        <= h_cnt_s;
            pix_y_r        <= v_cnt_s;
            video_active_r <= h_act_s && v_act_s;
            hsync_r        <= sync_level(h_sync_s, HSYNC_POL);
            vsync_r        <= sync_level(v_sync_s, VSYNC_POL);
            line_start_r   <= h_first_s;
            frame_start_r  <= frame_first_s;
        end else begin
            pix_x_r        <= pix_x_r;
            pix_y_r        <= pix_y_r;
            video_active_r <= video_active_r;
            hsync_r        <= hsync_r;
            vsync_r        <= vsync_r;
            line_start_r   <= 1'b0;
            frame_start_r  <= 1'b0;
        end
    end

    // Frame counter: a completed frame arms the increment so the first frame after reset stays 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= '0;
            wrap_pend_r <= 1'b0;
        end else if (en) begin
            if (frame_first_s && wrap_pend_r) begin
                frame_cnt_r <= frame_cnt_r + 10'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
            if (frame_wrap_s) begin
                wrap_pend_r <= 1'b1;
            end else if (frame_first_s) begin
                wrap_pend_r <= 1'b0;
            end else begin
                wrap_pend_r <= wrap_pend_r;
            end
        end else begin
            frame_cnt_r <= frame_cnt_r;
            wrap_pend_r <= wrap_pend_r;
        end
    end

    assign hsync        = hsync_r;
    assign vsync        = vsync_r;
    assign video_active = video_active_r;
    assign pix_x        = pix_x_r;
    assign pix_y        = pix_y_r;
    assign line_start   = line_start_r;
    assign frame_start  = frame_start_r;
    assign frame_cnt    = frame_cnt_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen. Three instances: default XGA,
// a short frame (H 8/1/2/1, V 4/1/1/1, positive syncs) and a tiny frame
// (all 1) used to reach the frame-counter wrap quickly.
module tb_video_timing_gen;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        va;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
        logic [9:0]  fc;
    } out_t;

    typedef struct {
        int    cyc;
        int    d;
        string nm;
        out_t  exp;
    } exp_t;

    logic        clk = 1'b0;
    logic [2:0]  rst_n_v;
    logic [2:0]  en_v;
    logic [10:0] px [3];
    logic [10:0] py [3];
    logic        va_o [3];
    logic        hs_o [3];
    logic        vs_o [3];
    logic        ls_o [3];
    logic        fs_o [3];
    logic [9:0]  fc_o [3];

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    event chk_ev;

    // Timing parameters of the three instances, as the bench's model sees them.
    int p_ha [3] = '{1024, 8, 1};
    int p_hf [3] = '{24, 1, 1};
    int p_hs [3] = '{136, 2, 1};
    int p_hb [3] = '{160, 1, 1};
    int p_va [3] = '{768, 4, 1};
    int p_vf [3] = '{3, 1, 1};
    int p_vs [3] = '{6, 1, 1};
    int p_vb [3] = '{29, 1, 1};
    bit p_hp [3] = '{1'b0, 1'b1, 1'b0};
    bit p_vp [3] = '{1'b0, 1'b1, 1'b0};

    int   mx [3];
    int   my [3];
    int   mfc [3];
    bit   seen [3];
    out_t mo [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    video_timing_gen #(.DISPLAY_MODE(1)) u_xga (
        .clk(clk), .rst_n(rst_n_v[0]), .en(en_v[0]), .hsync(hs_o[0]), .vsync(vs_o[0]),
        .video_active(va_o[0]), .pix_x(px[0]), .pix_y(py[0]), .line_start(ls_o[0]),
        .frame_start(fs_o[0]), .frame_cnt(fc_o[0])
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) u_small (
        .clk(clk), .rst_n(rst_n_v[1]), .en(en_v[1]), .hsync(hs_o[1]), .vsync(vs_o[1]),
        .video_active(va_o[1]), .pix_x(px[1]), .pix_y(py[1]), .line_start(ls_o[1]),
        .frame_start(fs_o[1]), .frame_cnt(fc_o[1])
    );

    video_timing_gen #(
        .H_ACTIVE(1), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) u_tiny (
        .clk(clk), .rst_n(rst_n_v[2]), .en(en_v[2]), .hsync(hs_o[2]), .vsync(vs_o[2]),
        .video_active(va_o[2]), .pix_x(px[2]), .pix_y(py[2]), .line_start(ls_o[2]),
        .frame_start(fs_o[2]), .frame_cnt(fc_o[2])
    );

    function automatic out_t mk(int x, int y, bit va, bit hs, bit vs, bit ls, bit fs, int fc);
        out_t o;
        o.x = 11'(x);  o.y = 11'(y);
        o.va = va;  o.hs = hs;  o.vs = vs;  o.ls = ls;  o.fs = fs;
        o.fc = 10'(fc);
        return o;
    endfunction

    function automatic out_t sample(int d);
        out_t o;
        o.x = px[d];  o.y = py[d];
        o.va = va_o[d];  o.hs = hs_o[d];  o.vs = vs_o[d];
        o.ls = ls_o[d];  o.fs = fs_o[d];  o.fc = fc_o[d];
        return o;
    endfunction

    task automatic push(int when, int d, string nm, out_t e);
        exp_t ent;
        ent.cyc = when;  ent.d = d;  ent.nm = nm;  ent.exp = e;
        q.push_back(ent);
    endtask

    task automatic model_reset(int d);
        mx[d] = 0;  my[d] = 0;  mfc[d] = 0;  seen[d] = 1'b0;
        mo[d] = mk(0, 0, 1'b0, ~p_hp[d], ~p_vp[d], 1'b0, 1'b0, 0);
    endtask

    // Behavioural model of one clock edge: present the next position, then advance.
    task automatic model_step(int d, bit e);
        int  ht;
        int  vt;
        bit  hwin;
        bit  vwin;
        ht = p_ha[d] + p_hf[d] + p_hs[d] + p_hb[d];
        vt = p_va[d] + p_vf[d] + p_vs[d] + p_vb[d];
        if (!e) begin
            mo[d].ls = 1'b0;
            mo[d].fs = 1'b0;
        end else begin
            hwin = (mx[d] >= p_ha[d] + p_hf[d]) && (mx[d] < p_ha[d] + p_hf[d] + p_hs[d]);
            vwin = (my[d] >= p_va[d] + p_vf[d]) && (my[d] < p_va[d] + p_vf[d] + p_vs[d]);
            mo[d].x  = 11'(mx[d]);
            mo[d].y  = 11'(my[d]);
            mo[d].ls = (mx[d] == 0);
            mo[d].fs = (mx[d] == 0) && (my[d] == 0);
            if (mo[d].fs) begin
                if (seen[d]) mfc[d] = (mfc[d] + 1) % 1024;
                seen[d] = 1'b1;
            end
            mo[d].fc = 10'(mfc[d]);
            mo[d].va = (mx[d] < p_ha[d]) && (my[d] < p_va[d]);
            mo[d].hs = hwin ? p_hp[d] : ~p_hp[d];
            mo[d].vs = vwin ? p_vp[d] : ~p_vp[d];
            mx[d] = mx[d] + 1;
            if (mx[d] == ht) begin
                mx[d] = 0;
                my[d] = (my[d] + 1 == vt) ? 0 : my[d] + 1;
            end
        end
    endtask

    task automatic step(int d, bit e, string nm);
        en_v[d] = e;
        model_step(d, e);
        push(cyc + 1, d, nm, mo[d]);
        @(posedge clk); #1;
    endtask

    // Same as step, plus a hand-computed expectation for that edge.
    task automatic step_hand(int d, bit e, string nm, out_t hand);
        en_v[d] = e;
        model_step(d, e);
        push(cyc + 1, d, nm, mo[d]);
        push(cyc + 1, d, {nm, "_hand"}, hand);
        @(posedge clk); #1;
    endtask

    task automatic reset_cycle(int d, string nm);
        rst_n_v[d] = 1'b0;
        en_v[d]    = 1'b1;
        model_reset(d);
        push(cyc + 1, d, nm, mo[d]);
        @(posedge clk); #1;
    endtask

    // Monitor: compare queued expectations on the falling edge or on demand.
    initial begin
        exp_t e;
        out_t a;
        forever begin
            @(negedge clk or chk_ev);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                a = sample(e.d);
                checks++;
                if (e.cyc != cyc || a !== e.exp) begin
                    errors++;
                    $display("FAIL %s dut%0d cyc%0d: got x=%0d y=%0d va=%b hs=%b vs=%b ls=%b fs=%b fc=%0d, want x=%0d y=%0d va=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                             e.nm, e.d, cyc, a.x, a.y, a.va, a.hs, a.vs, a.ls, a.fs, a.fc,
                             e.exp.x, e.exp.y, e.exp.va, e.exp.hs, e.exp.vs, e.exp.ls, e.exp.fs, e.exp.fc);
                end
            end
        end
    end

    initial begin
        rst_n_v = 3'b000;
        en_v    = 3'b000;
        for (int d = 0; d < 3; d++) model_reset(d);
        @(posedge clk); #1;

        // ---- XGA: reset, first edge, line 0, line 1 start ----
        repeat (3) reset_cycle(0, "xga_reset");
        push(cyc, 0, "xga_reset_hand", mk(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0));
        rst_n_v[0] = 1'b1;
        step_hand(0, 1'b1, "xga_first", mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0));
        repeat (1343) step(0, 1'b1, "xga_line0");
        step_hand(0, 1'b1, "xga_line1", mk(0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0));

        // ---- XGA: stall mid-line at x=500 ----
        repeat (500) step(0, 1'b1, "xga_to500");
        repeat (5) step_hand(0, 1'b0, "xga_stall", mk(500, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0));
        step_hand(0, 1'b1, "xga_resume", mk(501, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0));

        // ---- XGA: stall on a line_start cycle ----
        repeat (842) step(0, 1'b1, "xga_line1_tail");
        step_hand(0, 1'b1, "xga_line2", mk(0, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0));
        repeat (2) step_hand(0, 1'b0, "xga_ls_stall", mk(0, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0));
        step(0, 1'b1, "xga_ls_resume");

        // ---- XGA: asynchronous reset mid-frame at x=700 ----
        repeat (699) step(0, 1'b1, "xga_to700");
        @(negedge clk); #1;
        rst_n_v[0] = 1'b0;
        model_reset(0);
        push(cyc, 0, "xga_async_rst", mk(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0));
        #1;
        -> chk_ev;
        @(posedge clk); #1;
        repeat (2) reset_cycle(0, "xga_rst_hold");
        rst_n_v[0] = 1'b1;
        step_hand(0, 1'b1, "xga_restart", mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0));
        repeat (20) step(0, 1'b1, "xga_restart_run");
        en_v[0] = 1'b0;

        // ---- Short frame: 12x7, positive syncs, three full frames ----
        repeat (2) reset_cycle(1, "small_reset");
        rst_n_v[1] = 1'b1;
        step_hand(1, 1'b1, "small_first", mk(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0));
        repeat (251) step(1, 1'b1, "small_run");
        step_hand(1, 1'b1, "small_frame3", mk(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3));
        for (int i = 1; i < 12; i++) begin
            step_hand(1, 1'b1, "small_hwin",
                      mk(i, 0, (i < 8), (i == 9 || i == 10), 1'b0, 1'b0, 1'b0, 3));
        end
        repeat (72) step(1, 1'b1, "small_tail");
        en_v[1] = 1'b0;

        // ---- Tiny frame: 4x4, run 1025 frames to see frame_cnt wrap ----
        repeat (2) reset_cycle(2, "tiny_reset");
        rst_n_v[2] = 1'b1;
        repeat (16 * 1023) step(2, 1'b1, "tiny_run");
        step_hand(2, 1'b1, "tiny_fc1023", mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1023));
        repeat (15) step(2, 1'b1, "tiny_last");
        step_hand(2, 1'b1, "tiny_fc_wrap", mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0));
        repeat (18) step(2, 1'b1, "tiny_after");
        en_v[2] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
